// File: rtl/if_id_reg_if.sv
// rtl/if_id_reg_if.sv - IF/ID pipeline register signal bundle
// master drives fetch-side controls/data; slave is the IF/ID register itself.
interface if_id_reg_if;
  logic        en;
  logic        flush;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        id_is_jb;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc8_id;
  logic [4:0]  exccode_id;
  logic        bd_id;
  logic        valid_id;

  modport master (
    output en, flush, pc_if, instr_if, id_is_jb,
    input  instr_id, pc_id, pc8_id, exccode_id, bd_id, valid_id
  );

  modport slave (
    input  en, flush, pc_if, instr_if, id_is_jb,
    output instr_id, pc_id, pc8_id, exccode_id, bd_id, valid_id
  );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with fetch AdEL detection
// Priority each posedge: reset > flush > stall (en=1) > load.
module if_id_reg #(
  parameter logic [31:0] PC_RESET  = 32'h00003000,
  parameter logic [31:0] IM_BASE   = 32'h00003000,
  parameter logic [31:0] IM_LIMIT  = 32'h00006FFC,
  parameter logic [4:0]  ADEL_CODE = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  if_id_reg_if.slave  bus
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic        valid_q, valid_d;
  logic        fetch_fault;

  assign fetch_fault = (bus.pc_if[1:0] != 2'b00) ||
                       (bus.pc_if < IM_BASE) ||
                       (bus.pc_if > IM_LIMIT);

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (!bus.en) begin
      pc_d    = bus.pc_if;
      pc8_d   = bus.pc_if + 32'd8;
      valid_d = 1'b1;
      // Delay-slot flag comes from the ID occupant being replaced; bubbles never count.
      bd_d    = bus.id_is_jb & valid_q;
      if (fetch_fault) begin
        exc_d   = ADEL_CODE;
        instr_d = 32'h0;
      end else begin
        exc_d   = 5'd0;
        instr_d = bus.instr_if;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      instr_q <= 32'h0;
      pc_q    <= PC_RESET;
      pc8_q   <= PC_RESET + 32'd8;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  assign bus.instr_id   = instr_q;
  assign bus.pc_id      = pc_q;
  assign bus.pc8_id     = pc8_q;
  assign bus.exccode_id = exc_q;
  assign bus.bd_id      = bd_q;
  assign bus.valid_id   = valid_q;

endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - scoreboard bench for if_id_reg
module tb_if_id_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          en;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          jb;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t m;
  exp_t sb[$];

  if_id_reg_if bus();

  if_id_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    observed = {bus.instr_id, bus.pc_id, bus.pc8_id, bus.exccode_id, bus.bd_id, bus.valid_id};
  endfunction

  task automatic step(input stim_t s);
    exp_t n;
    bit   fault;
    reset        = s.rst;
    bus.flush    = s.fl;
    bus.en       = s.en;
    bus.pc_if    = s.pc;
    bus.instr_if = s.instr;
    bus.id_is_jb = s.jb;
    if (s.rst || s.fl) begin
      n = '{instr: 32'h0, pc: 32'h3000, pc8: 32'h3008, exc: 5'd0, bd: 1'b0, valid: 1'b0};
    end else if (s.en) begin
      n = m;
    end else begin
      fault   = (s.pc[1:0] != 2'b00) || (s.pc < 32'h3000) || (s.pc > 32'h6FFC);
      n.pc    = s.pc;
      n.pc8   = s.pc + 32'd8;
      n.valid = 1'b1;
      n.bd    = s.jb & m.valid;
      n.exc   = fault ? 5'd4 : 5'd0;
      n.instr = fault ? 32'h0 : s.instr;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      step('{1, 1, 1, 32'h1234, 32'hDEAD, 1});
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", i, observed(), e);
      end
    end
    checks++;
    if (bus.pc8_id !== 32'h3008 || bus.valid_id !== 1'b0 || bus.instr_id !== 32'h0) begin
      errors++;
      $display("FAIL reset_const: got pc8=%h valid=%b instr=%h want 3008/0/0", bus.pc8_id, bus.valid_id, bus.instr_id);
    end
  endtask

  task automatic test_straight();
    stim_t st[2] = '{'{0, 0, 0, 32'h3000, 32'h24010005, 0},
                     '{0, 0, 0, 32'h3004, 32'h00000000, 0}};
    exp_t e;
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL straight[%0d]: got %h want %h", i, observed(), e);
      end
      if (i == 0) begin
        checks++;
        if (bus.instr_id !== 32'h24010005 || bus.pc8_id !== 32'h3008 || bus.valid_id !== 1'b1) begin
          errors++;
          $display("FAIL straight_const: got instr=%h pc8=%h valid=%b want 24010005/3008/1", bus.instr_id, bus.pc8_id, bus.valid_id);
        end
      end
    end
  endtask

  task automatic test_delay_slot();
    stim_t st[4] = '{'{0, 0, 0, 32'h3008, 32'h11110001, 1},
                     '{0, 1, 0, 32'h300C, 32'h0, 0},
                     '{0, 0, 0, 32'h300C, 32'h22220002, 1},
                     '{0, 0, 0, 32'h3010, 32'h33330003, 0}};
    bit want_bd[4] = '{1, 0, 0, 0};
    exp_t e;
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observed() !== e || bus.bd_id !== want_bd[i]) begin
        errors++;
        $display("FAIL delay_slot[%0d]: got %h bd=%b want %h bd=%b", i, observed(), bus.bd_id, e, want_bd[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    stim_t st[6] = '{'{0, 0, 0, 32'h3100, 32'hAAAA0000, 0},
                     '{0, 0, 1, 32'h3200, 32'hBBBB0000, 1},
                     '{0, 0, 1, 32'h3300, 32'hCCCC0000, 1},
                     '{0, 0, 1, 32'h3002, 32'hDDDD0000, 0},
                     '{0, 1, 1, 32'h3400, 32'hEEEE0000, 1},
                     '{0, 0, 0, 32'h4180, 32'h12345678, 1}};
    exp_t e;
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL stall_flush[%0d]: got %h want %h", i, observed(), e);
      end
      if (i == 3) begin
        checks++;
        if (bus.pc_id !== 32'h3100 || bus.instr_id !== 32'hAAAA0000) begin
          errors++;
          $display("FAIL stall_hold: got pc=%h instr=%h want 3100/aaaa0000", bus.pc_id, bus.instr_id);
        end
      end
    end
    checks++;
    if (bus.pc_id !== 32'h4180 || bus.valid_id !== 1'b1 || bus.bd_id !== 1'b0) begin
      errors++;
      $display("FAIL release_after_flush: got pc=%h valid=%b bd=%b want 4180/1/0", bus.pc_id, bus.valid_id, bus.bd_id);
    end
  endtask

  task automatic test_faults();
    stim_t st[6] = '{'{0, 0, 0, 32'h3002, 32'h01010101, 0},
                     '{0, 0, 0, 32'h6FFC, 32'h02020202, 0},
                     '{0, 0, 0, 32'h7000, 32'h03030303, 0},
                     '{0, 0, 0, 32'h2FFC, 32'h04040404, 0},
                     '{0, 0, 0, 32'h7001, 32'h05050505, 0},
                     '{0, 0, 0, 32'h3000, 32'h06060606, 0}};
    logic [4:0] want_exc[6] = '{5'd4, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0};
    exp_t e;
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if (observed() !== e || bus.exccode_id !== want_exc[i]) begin
        errors++;
        $display("FAIL fault[%0d] pc=%h: got %h exc=%0d want %h exc=%0d", i, st[i].pc, observed(), bus.exccode_id, e, want_exc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    step('{0, 0, 0, 32'hFFFFFFFC, 32'h77777777, 0});
    e = sb.pop_front();
    checks++;
    if (observed() !== e || bus.pc8_id !== 32'h00000004 || bus.exccode_id !== 5'd4 || bus.instr_id !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %h want %h (pc8=4 exc=4)", observed(), e);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 60; i++) begin
      s.rst   = ($urandom_range(0, 19) == 0);
      s.fl    = ($urandom_range(0, 7) == 0);
      s.en    = ($urandom_range(0, 3) == 0);
      s.pc    = 32'h2FF8 + $urandom_range(0, 32'h4010);
      s.instr = $urandom;
      s.jb    = $urandom_range(0, 1);
      step(s);
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, observed(), e);
      end
    end
  endtask

  initial begin
    m = '{instr: 32'h0, pc: 32'h3000, pc8: 32'h3008, exc: 5'd0, bd: 1'b0, valid: 1'b0};
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.flush    = 1'b1;
    bus.pc_if    = 32'h0;
    bus.instr_if = 32'h0;
    bus.id_is_jb = 1'b0;
    test_reset();
    test_straight();
    test_delay_slot();
    test_stall_flush();
    test_faults();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage MIPS core.
- Captures the fetch PC from the program counter and the instruction-memory word, and presents them to decode.
- Adds fetch-side precise-exception bookkeeping: AdEL detection, NOP substitution, a branch-delay-slot flag and a valid bit.
- Obeys the same stall signal (en high = hold) as the PC register, so IF and ID freeze together.

Parameters:
- PC_RESET, 32'h00003000, pc_id value after reset and in bubbles
- IM_BASE, 32'h00003000, lowest legal fetch address
- IM_LIMIT, 32'h00006FFC, highest legal fetch address (inclusive)
- ADEL_CODE, 5'd4, ExcCode written for a fetch address error

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- en  in  1  stall; 1 = hold all state, 0 = load
- flush  in  1  exception/eret flush; insert bubble
- pc_if  in  32  current PC (PC register output)
- instr_if  in  32  instruction-memory data for pc_if
- id_is_jb  in  1  instruction currently in ID is a branch/jump (from decoder)
- instr_id  out  32  instruction to decode
- pc_id  out  32  PC of instr_id
- pc8_id  out  32  pc_id + 8 (link address)
- exccode_id  out  5  pending exception code, 0 = none
- bd_id  out  1  instr_id sits in a branch delay slot
- valid_id  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Priority per posedge: reset > flush > en > load.
- Reset and bubble values: instr_id=0, pc_id=PC_RESET, pc8_id=PC_RESET+8, exccode_id=0, bd_id=0, valid_id=0.
- reset=1 loads the reset/bubble values. Reset mid-stall or mid-flush still wins.
- flush=1 (reset=0) loads the bubble values regardless of en. Flush overrides stall because the exception redirect must not be blocked.
- en=1 (reset=0, flush=0): every output holds its value. id_is_jb is ignored.
- Load (reset=0, flush=0, en=0): pc_id<=pc_if; pc8_id<=pc_if+32'd8 (mod 2^32, no overflow trap); valid_id<=1; bd_id<=id_is_jb & valid_id. The delay-slot flag is taken from the ID occupant being replaced, and a bubble never marks a delay slot.
- Fetch address error on load: pc_if[1:0]!=0, or pc_if<IM_BASE, or pc_if>IM_LIMIT (unsigned compares).
  - If error: exccode_id<=ADEL_CODE, instr_id<=32'h0 (NOP), valid_id<=1. The faulting PC is still carried for EPC.
  - Else: exccode_id<=0, instr_id<=instr_if.
- Latency: one cycle from pc_if/instr_if to ID outputs. No combinational path from inputs to outputs.
- Boundaries:
  - pc_if=IM_LIMIT is legal; IM_LIMIT+4 faults.
  - pc_if=IM_BASE-4 faults.
  - Misalignment and range faults together yield a single ADEL_CODE.
  - pc_if=32'hFFFFFFFC gives pc8_id=32'h00000004 (and faults).
  - flush and en both high gives a bubble.
  - A stall released in the cycle after a flush loads normally, with bd_id=0 because the ID occupant is a bubble.
- Outputs hold indefinitely under continuous stall.

Test Plan:
- Reset: assert reset 2 cycles with en=1, flush=1 -> instr_id=0, pc_id=0x3000, pc8_id=0x3008, valid_id=0, exccode_id=0, bd_id=0.
- Straight-line fetch: pc_if=0x3000/instr 0x24010005, then 0x3004/0x00000000 -> next cycles pc_id=0x3000, pc8_id=0x3008, instr_id=0x24010005, valid=1; then pc_id=0x3004, bd_id=0.
- Delay slot: ID holds valid beq with id_is_jb=1, load pc_if=0x3008 -> bd_id=1. Repeat with ID bubble (valid_id=0) and id_is_jb=1 -> bd_id=0.
- Stall/flush priority: en=1 for 3 cycles with changing pc_if -> outputs frozen. Then en=1 & flush=1 -> bubble values. Then en=0, pc_if=0x4180 -> pc_id=0x4180, valid=1, bd_id=0.
- Fetch faults: pc_if=0x3002 -> exccode_id=4, instr_id=0, valid=1, pc_id=0x3002. pc_if=0x6FFC -> exccode_id=0. pc_if=0x7000 -> exccode_id=4. pc_if=0x2FFC -> exccode_id=4.
- Wrap: pc_if=0xFFFFFFFC -> pc8_id=0x00000004, exccode_id=4.
